// File: rtl/seg_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_link_pkg
// Desc   : Shared constants and state encodings for the serial 7-seg link.
// Rev    : 1.0
// ============================================================================
package seg_link_pkg;

    localparam int SEG_NBITS = 64;
    localparam int SEG_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } seg_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_in_sync.sv
`default_nettype none
// ============================================================================
// Module : seg_in_sync
// Desc   : Multi-flop input synchroniser with rise/fall pulses taken against
//          one extra registered copy of the synchronised level.
// Rev    : 1.0
// ============================================================================
module seg_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic CLK,
    input  logic Reset,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/seg_serial_rx.sv
`default_nettype none
// ============================================================================
// Module : seg_serial_rx
// Desc   : Oversampling receiver for the 4-wire serial 7-seg link; captures
//          one NBITS-bit frame per PEN strobe and flags length errors.
// Rev    : 1.0
// ============================================================================
module seg_serial_rx
    import seg_link_pkg::*;
#(
    parameter int NBITS       = SEG_NBITS,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = SEG_CNT_W
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             seg_clk_i,
    input  logic             seg_do_i,
    input  logic             seg_pen_i,
    input  logic             seg_clr_i,
    output logic [NBITS-1:0] frame_o,
    output logic             frame_valid_o,
    output logic             err_len_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(NBITS);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(NBITS + 1);

    logic clk_rise;
    logic do_lvl;
    logic pen_rise;
    logic pen_fall;
    logic clr_lvl;
    logic clk_lvl_unused, clk_fall_unused;
    logic do_rise_unused, do_fall_unused;
    logic pen_lvl_unused;
    logic clr_rise_unused, clr_fall_unused;

    seg_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .CLK(CLK), .Reset(Reset), .d_i(seg_clk_i),
        .lvl_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall_unused)
    );
    seg_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_do (
        .CLK(CLK), .Reset(Reset), .d_i(seg_do_i),
        .lvl_o(do_lvl), .rise_o(do_rise_unused), .fall_o(do_fall_unused)
    );
    seg_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_pen (
        .CLK(CLK), .Reset(Reset), .d_i(seg_pen_i),
        .lvl_o(pen_lvl_unused), .rise_o(pen_rise), .fall_o(pen_fall)
    );
    seg_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clr (
        .CLK(CLK), .Reset(Reset), .d_i(seg_clr_i),
        .lvl_o(clr_lvl), .rise_o(clr_rise_unused), .fall_o(clr_fall_unused)
    );

    seg_state_e       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NBITS-1:0] frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_len_q, err_len_d;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            count_q       <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            count_q       <= count_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            err_len_q     <= err_len_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        count_d       = count_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        err_len_d     = 1'b0;
        // A held clear overrides every other event, including a pending latch.
        if (!clr_lvl) begin
            state_d = ST_IDLE;
            shreg_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pen_fall) begin
                        state_d = ST_SHIFT;
                        count_d = '0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = {shreg_q[NBITS-2:0], do_lvl};
                        count_d = (count_q == c_cnt_sat) ? c_cnt_sat : count_q + 1'b1;
                    end
                    if (pen_rise) begin
                        state_d = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (count_q == c_cnt_full) begin
                        frame_d       = shreg_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        err_len_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign frame_o       = frame_q;
    assign frame_valid_o = frame_valid_q;
    assign err_len_o     = err_len_q;
    assign busy_o        = (state_q == ST_SHIFT);
    assign bit_cnt_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_serial_rx
// Desc   : Directed scoreboard bench for the serial 7-seg link receiver.
// Rev    : 1.0
// ============================================================================
module tb_seg_serial_rx;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        seg_clk_i = 1'b0;
    logic        seg_do_i = 1'b0;
    logic        seg_pen_i = 1'b1;
    logic        seg_clr_i = 1'b1;
    logic [63:0] frame_o;
    logic        frame_valid_o;
    logic        err_len_o;
    logic        busy_o;
    logic [6:0]  bit_cnt_o;

    seg_serial_rx dut (
        .CLK(CLK), .Reset(Reset),
        .seg_clk_i(seg_clk_i), .seg_do_i(seg_do_i),
        .seg_pen_i(seg_pen_i), .seg_clr_i(seg_clr_i),
        .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .err_len_o(err_len_o), .busy_o(busy_o), .bit_cnt_o(bit_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_err;
        logic [63:0] frame;
        int          pen_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (frame_valid_o || err_len_o) begin
                check("pulse_excl", {63'd0, frame_valid_o & err_len_o}, 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {62'd0, frame_valid_o, err_len_o}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_kind", {62'd0, frame_valid_o, err_len_o},
                          e.is_err ? 64'd1 : 64'd2);
                    check("pulse_frame", frame_o, e.frame);
                    check("pulse_latency", 64'(cyc - e.pen_cyc), 64'd4);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK);
        seg_do_i  = b;
        seg_clk_i = 1'b0;
        wait_cyc(8);
        seg_clk_i = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pen_fall();
        @(negedge CLK);
        seg_pen_i = 1'b0;
        wait_cyc(8);
    endtask

    task automatic pen_rise_expect(input logic is_err, input logic [63:0] f);
        exp_t e;
        @(negedge CLK);
        seg_pen_i = 1'b1;
        e.is_err  = is_err;
        e.frame   = f;
        e.pen_cyc = cyc;
        sb_q.push_back(e);
        wait_cyc(12);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_frame", frame_o, 64'd0);
        check("rst_valid", {63'd0, frame_valid_o}, 64'd0);
        check("rst_err", {63'd0, err_len_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_cnt", {57'd0, bit_cnt_o}, 64'd0);
        Reset = 1'b1;
        wait_cyc(8);

        // Shift clocks while PEN is high are ignored
        send_word(64'h5, 5);
        check("idle_cnt", {57'd0, bit_cnt_o}, 64'd0);
        check("idle_busy", {63'd0, busy_o}, 64'd0);
        check("idle_frame", frame_o, 64'd0);

        // Good 64-bit frame
        pen_fall();
        check("shift_busy", {63'd0, busy_o}, 64'd1);
        send_word(64'hDEADBEEF_01234567, 64);
        check("full_cnt", {57'd0, bit_cnt_o}, 64'd64);
        pen_rise_expect(1'b0, 64'hDEADBEEF_01234567);
        check("full_frame", frame_o, 64'hDEADBEEF_01234567);
        check("full_busy", {63'd0, busy_o}, 64'd0);

        // Short frame of 63 bits
        pen_fall();
        send_word(64'h0F0F_0F0F_0F0F_0F0F, 63);
        check("short_cnt", {57'd0, bit_cnt_o}, 64'd63);
        pen_rise_expect(1'b1, 64'hDEADBEEF_01234567);
        check("short_frame", frame_o, 64'hDEADBEEF_01234567);

        // Overlong frame of 70 bits
        pen_fall();
        send_word(64'h2A, 6);
        send_word(64'hFFFF0000_AAAA5555, 64);
        check("long_cnt", {57'd0, bit_cnt_o}, 64'd65);
        pen_rise_expect(1'b1, 64'hDEADBEEF_01234567);
        check("long_frame", frame_o, 64'hDEADBEEF_01234567);

        // Clear mid-frame, then shifts without a new PEN fall are ignored
        pen_fall();
        send_word(64'hCAFEF00D, 32);
        @(negedge CLK);
        seg_clr_i = 1'b0;
        wait_cyc(8);
        check("clr_cnt", {57'd0, bit_cnt_o}, 64'd0);
        check("clr_busy", {63'd0, busy_o}, 64'd0);
        check("clr_frame", frame_o, 64'hDEADBEEF_01234567);
        seg_clr_i = 1'b1;
        wait_cyc(8);
        send_word(64'h9, 4);
        check("clr_noshift_cnt", {57'd0, bit_cnt_o}, 64'd0);
        @(negedge CLK);
        seg_pen_i = 1'b1;
        wait_cyc(8);
        pen_fall();
        send_word(64'h1, 64);
        pen_rise_expect(1'b0, 64'h1);
        check("clr_after_frame", frame_o, 64'h1);

        // Asynchronous reset mid-frame
        pen_fall();
        send_word(64'hABCDE, 20);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("amid_frame", frame_o, 64'd0);
        check("amid_cnt", {57'd0, bit_cnt_o}, 64'd0);
        check("amid_busy", {63'd0, busy_o}, 64'd0);
        check("amid_pulses", {62'd0, frame_valid_o, err_len_o}, 64'd0);
        seg_pen_i = 1'b1;
        seg_clk_i = 1'b0;
        wait_cyc(4);
        Reset = 1'b1;
        send_word(64'h3, 4);
        check("post_rst_cnt", {57'd0, bit_cnt_o}, 64'd0);
        check("post_rst_busy", {63'd0, busy_o}, 64'd0);

        // Recovery frame after reset
        pen_fall();
        send_word(64'h0123_4567_89AB_CDEF, 64);
        pen_rise_expect(1'b0, 64'h0123_4567_89AB_CDEF);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge CLK);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        wait_cyc(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
